seg7_scan_controller: RTL and testbench

- Time-multiplexed scan controller for a bank of common-cathode 7-segment digits.
- One segment bus is shared by NUM_DIGITS digits, each showing a 3-bit value (0-7), using a one-hot digit enable.
- Holds a double-buffered digit frame loaded through a valid/ready handshake, and inserts blanking between digits to suppress ghosting.
- Sits between the 3-bit datapath logic and the display pins.

---
 rtl/seg7_scan_controller.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for common-cathode 7-segment digits with a double-buffered frame.
// Optional: define SEG7_SCAN_PWM_EN to add a brightness[3:0] input that dims each SHOW slot.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
`ifdef SEG7_SCAN_PWM_EN
  input  logic [3:0]              brightness,
`endif
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [3*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3*NUM_DIGITS-1:0] active_q, pend_q;
  logic [NUM_DIGITS-1:0]   activeDp_q, pendDp_q;
  logic                    ready_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digitEn_q, digitEn_d;
  logic                    frameDone_q;
  logic                    frameEnd;
  logic                    loadFire;
  logic                    lit;
  logic [2:0]              digitVal [NUM_DIGITS];

  function automatic logic [6:0] decode(input logic [2:0] v);
    case (v)
      3'd0:    decode = 7'h3F;
      3'd1:    decode = 7'h06;
      3'd2:    decode = 7'h5B;
      3'd3:    decode = 7'h4F;
      3'd4:    decode = 7'h66;
      3'd5:    decode = 7'h6D;
      3'd6:    decode = 7'h7D;
      default: decode = 7'h07;
    endcase
  endfunction

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unpack
    assign digitVal[g] = active_q[3*g +: 3];
  end

  assign loadFire = load_valid & ready_q;

  // Dropping enable wins over everything, including a pending frame-end swap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frameEnd = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              frameEnd = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SEG7_SCAN_PWM_EN
  logic [3:0]  bright_q;
  logic [3:0]  brightSel;
  logic [31:0] pwmLimit;

  // Brightness is latched once per slot so the duty cycle cannot change mid-digit.
  assign brightSel = (state_q == BLANK && state_d == SHOW) ? brightness : bright_q;
  assign pwmLimit  = ((32'(brightSel) + 32'd1) * 32'(SHOW_CYCLES)) >> 4;
  assign lit       = (32'(cnt_d) < pwmLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bright_q <= 4'hF;
    else       bright_q <= brightSel;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    seg_d     = '0;
    dp_d      = 1'b0;
    digitEn_d = '0;
    if (state_d == SHOW && lit) begin
      digitEn_d = NUM_DIGITS'(1) << idx_d;
      seg_d     = decode(digitVal[idx_d]);
      dp_d      = activeDp_q[idx_d];
    end
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      activeDp_q  <= '0;
      pend_q      <= '0;
      pendDp_q    <= '0;
      ready_q     <= 1'b1;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      digitEn_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digitEn_q   <= digitEn_d;
      frameDone_q <= frameEnd;
      if (loadFire) begin
        pend_q   <= load_data;
        pendDp_q <= load_dp;
        ready_q  <= 1'b0;
      end else if (frameEnd && !ready_q) begin
        active_q   <= pend_q;
        activeDp_q <= pendDp_q;
        ready_q    <= 1'b1;
      end
    end
  end

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digitEn_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: stimulus queues expected digit slots, a monitor pops and compares.
// With SEG7_SCAN_PWM_EN defined the brightness input is tied to full-on so the same expectations apply.
module tb_seg7_scan_controller;

  localparam int ND    = 4;
  localparam int SHOW  = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [11:0] load_data;
  logic [3:0]  load_dp;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;
`ifdef SEG7_SCAN_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;
  } slot_t;

  slot_t expQ[$];

  bit         monActive  = 1'b1;
  bit         skipPeriod = 1'b0;
  int         cyc        = 0;
  int         fdPrev     = -1;
  int         runLen     = 0;
  int         gapLen     = 0;
  int         runGap     = 0;
  int         slotNum    = 0;
  logic [3:0] runEn      = 4'h0;
  logic [3:0] prevEn     = 4'h0;
  logic [6:0] runSeg     = 7'h0;
  logic       runDp      = 1'b0;
  bit         runGlitch  = 1'b0;

  seg7_scan_controller #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SHOW),
    .BLANK_CYCLES(BLANK),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
`ifdef SEG7_SCAN_PWM_EN
    .brightness(brightness),
`endif
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_dp   (load_dp),
    .seg       (seg),
    .dp        (dp),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] data, input logic [3:0] dpm);
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dpm;
  endtask

  task automatic pushSlot(input logic [3:0] en, input logic [6:0] s, input logic d, input int len, input int gap);
    slot_t e;
    e.en  = en;
    e.seg = s;
    e.dp  = d;
    e.len = len;
    e.gap = gap;
    expQ.push_back(e);
  endtask

  // segs packs the four expected patterns as {digit3, digit2, digit1, digit0}.
  task automatic pushFrame(input logic [27:0] segs, input logic [3:0] dps, input int firstGap);
    for (int i = 0; i < ND; i++)
      pushSlot(4'(1 << i), segs[7*i +: 7], dps[i], SHOW, (i == 0) ? firstGap : BLANK);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic waitFrameDone(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeoutFail(name);
  endtask

  // want == 0 waits for any lit digit.
  task automatic waitEn(input string name, input logic [3:0] want);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((want == 4'h0 && digit_en != 4'h0) || (want != 4'h0 && digit_en == want)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeoutFail(name);
  endtask

  task automatic finishRun();
    slot_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL slot%0d: got en=%b seg=%h dp=%b len=%0d expected no slot",
               slotNum, runEn, runSeg, runDp, runLen);
    end else begin
      e = expQ.pop_front();
      if (runEn !== e.en || runSeg !== e.seg || runDp !== e.dp || runGlitch ||
          (e.len >= 0 && runLen != e.len) || (e.gap >= 0 && runGap != e.gap)) begin
        errors++;
        $display("[TB] FAIL slot%0d: got en=%b seg=%h dp=%b len=%0d gap=%0d glitch=%0b expected en=%b seg=%h dp=%b len=%0d gap=%0d",
                 slotNum, runEn, runSeg, runDp, runLen, runGap, runGlitch, e.en, e.seg, e.dp, e.len, e.gap);
      end
    end
    slotNum++;
  endtask

  // Monitor: every lit run of one digit is one slot; it is scored when the run ends.
  always @(negedge clk) begin
    cyc++;
    if (monActive) begin
      if (digit_en != 4'h0) begin
        if (runLen == 0 || digit_en != runEn) begin
          if (runLen != 0) finishRun();
          runEn     = digit_en;
          runSeg    = seg;
          runDp     = dp;
          runLen    = 1;
          runGap    = gapLen;
          runGlitch = 1'b0;
        end else begin
          runLen++;
          if (seg !== runSeg || dp !== runDp) runGlitch = 1'b1;
        end
        gapLen = 0;
      end else begin
        if (runLen != 0) finishRun();
        runLen = 0;
        gapLen++;
      end
      if (frame_done) begin
        checkOutput("frame_done_after_digit3", 32'(prevEn), 32'h8);
        if (fdPrev >= 0 && !skipPeriod)
          checkOutput("frame_period", 32'(cyc - fdPrev), 32'(ND * (SHOW + BLANK)));
        skipPeriod = 1'b0;
        fdPrev     = cyc;
      end
    end
    prevEn = digit_en;
  end

  initial begin
    int heldBad;
    bit swapSeen;
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_seg", 32'(seg), 32'h0);
    checkOutput("reset_digit_en", 32'(digit_en), 32'h0);
    checkOutput("reset_dp", 32'(dp), 32'h0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
    checkOutput("reset_load_ready", 32'(load_ready), 32'h1);

    // Frame 0 shows the all-zero reset frame; frame A follows after the first swap.
    pushFrame({4{7'h3F}}, 4'b0000, -1);
    pushFrame({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'b0100, BLANK);
    reset  = 1'b0;
    enable = 1'b1;
    applyStimulus({3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100);
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("blank_entry_dark", 32'(digit_en), 32'h0);
    checkOutput("ready_low_A_pending", 32'(load_ready), 32'h0);
    @(negedge clk);
    checkOutput("blank_second_dark", 32'(digit_en), 32'h0);
    @(negedge clk);
    checkOutput("first_digit_on", 32'(digit_en), 32'h1);

    waitFrameDone("frame0_end");
    checkOutput("ready_after_swap_A", 32'(load_ready), 32'h1);

    // Mid-frame load of B (decode sweep 4..7), then C held until the next boundary.
    repeat (15) @(negedge clk);
    applyStimulus({3'd7, 3'd6, 3'd5, 3'd4}, 4'b0000);
    pushFrame({7'h07, 7'h7D, 7'h6D, 7'h66}, 4'b0000, BLANK);
    @(negedge clk);
    applyStimulus({3'd5, 3'd3, 3'd0, 3'd7}, 4'b1001);
    checkOutput("ready_low_B_pending", 32'(load_ready), 32'h0);
    pushSlot(4'b0001, 7'h07, 1'b1, SHOW, BLANK);
    pushSlot(4'b0010, 7'h3F, 1'b0, SHOW, BLANK);
    pushSlot(4'b0100, 7'h4F, 1'b0, 3, BLANK);
    heldBad  = 0;
    swapSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        swapSeen = 1'b1;
        break;
      end
      if (load_ready !== 1'b0) heldBad++;
    end
    if (!swapSeen) timeoutFail("frame1_end");
    checkOutput("third_load_held_off", 32'(heldBad), 32'h0);
    checkOutput("ready_at_swap_B", 32'(load_ready), 32'h1);
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("ready_low_C_pending", 32'(load_ready), 32'h0);

    // Frame 2 shows B; drop enable three cycles into digit 2 of frame 3 (C).
    waitFrameDone("frame2_end");
    waitEn("frame3_digit2", 4'b0100);
    repeat (2) @(negedge clk);
    enable     = 1'b0;
    skipPeriod = 1'b1;
    @(negedge clk);
    checkOutput("disable_dark_en", 32'(digit_en), 32'h0);
    checkOutput("disable_dark_seg", 32'(seg), 32'h0);
    checkOutput("disable_dark_dp", 32'(dp), 32'h0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    pushFrame({7'h6D, 7'h4F, 7'h3F, 7'h07}, 4'b1001, 7);
    pushFrame({7'h6D, 7'h4F, 7'h3F, 7'h07}, 4'b1001, BLANK);
    waitFrameDone("restart_frame0_end");
    waitFrameDone("restart_frame1_end");
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    monActive = 1'b0;

    // Reset mid-slot with a frame pending: dark at once and the pending frame is dropped.
    applyStimulus({3'd1, 3'd1, 3'd1, 3'd1}, 4'b1111);
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("ready_low_D_pending", 32'(load_ready), 32'h0);
    waitEn("lit_before_reset", 4'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midslot_reset_en", 32'(digit_en), 32'h0);
    checkOutput("midslot_reset_seg", 32'(seg), 32'h0);
    checkOutput("midslot_reset_ready", 32'(load_ready), 32'h1);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
